// File: rtl/operand_entry.sv
// operand_entry: keypad front end of the calculator datapath.
// Accumulates decimal key digits into an unsigned binary operand and commits
// it with a one-cycle valid pulse on ENTER.
// Optional feature macro: OPERAND_ENTRY_BACKSPACE_EN (backspace key 0xB).
// When the macro is undefined, 0xB is a no-op and no divider is built.
module operand_entry #(
  parameter int unsigned width      = 8,
  parameter int unsigned max_digits = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [3:0]       key_code_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  output logic [width-1:0] value_o,
  output logic [3:0]       digit_count_o,
  output logic             overflow_o,
  output logic [width-1:0] operand_o,
  output logic             operand_valid_o
);

  // Candidate is computed four bits wider so value*10+d can never wrap.
  localparam int unsigned   cand_w       = width + 4;
  localparam logic [cand_w-1:0] max_value_c = {4'b0000, {width{1'b1}}};
  localparam logic [cand_w-1:0] ten_c       = cand_w'(4'd10);
  localparam logic [3:0]    max_digits_c = 4'(max_digits);

  localparam logic [3:0] key_enter_c = 4'hA;
  localparam logic [3:0] key_clear_c = 4'hC;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
  localparam logic [3:0] key_bksp_c  = 4'hB;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [width-1:0] value_q;
  logic [width-1:0] operand_q;
  logic [3:0]       count_q;
  logic             overflow_q;
  logic             valid_q;
  logic             ready_q;

  logic              key_accept_d;
  logic              is_digit_d;
  logic              digit_ok_d;
  logic [cand_w-1:0] cand_d;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
  logic [width-1:0]  value_div10_d;
`endif

  // Decode the incoming key and evaluate whether a digit can be appended.
  always_comb begin
    key_accept_d = key_valid_i & ready_q;
    is_digit_d   = (key_code_i <= 4'd9);
    cand_d       = ({4'b0000, value_q} * ten_c) + {{width{1'b0}}, key_code_i};
    if ((count_q < max_digits_c) && (cand_d <= max_value_c)) begin
      digit_ok_d = 1'b1;
    end else begin
      digit_ok_d = 1'b0;
    end
  end

`ifdef OPERAND_ENTRY_BACKSPACE_EN
  // Drop the last decimal digit (constant divide by ten).
  always_comb begin
    value_div10_d = value_q / width'(4'd10);
  end
`endif

  // Entry FSM with registered outputs; reset overrides any accepted key.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      value_q    <= '0;
      operand_q  <= '0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state_q)
        DONE: begin
          // Single bubble cycle after commit, then back to an empty entry.
          state_q    <= IDLE;
          value_q    <= '0;
          count_q    <= 4'd0;
          overflow_q <= 1'b0;
          valid_q    <= 1'b0;
          ready_q    <= 1'b1;
        end
        IDLE, ENTRY: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          if (key_accept_d) begin
            if (is_digit_d) begin
              if (digit_ok_d) begin
                value_q <= cand_d[width-1:0];
                count_q <= count_q + 4'd1;
                state_q <= ENTRY;
              end else begin
                // Rejected digit: keep value/count/state, flag it.
                overflow_q <= 1'b1;
              end
            end else begin
              case (key_code_i)
                key_enter_c: begin
                  operand_q <= value_q;
                  valid_q   <= 1'b1;
                  ready_q   <= 1'b0;
                  state_q   <= DONE;
                end
                key_clear_c: begin
                  value_q    <= '0;
                  count_q    <= 4'd0;
                  overflow_q <= 1'b0;
                  state_q    <= IDLE;
                end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
                key_bksp_c: begin
                  if (count_q != 4'd0) begin
                    value_q    <= value_div10_d;
                    count_q    <= count_q - 4'd1;
                    overflow_q <= 1'b0;
                    if (count_q == 4'd1) begin
                      state_q <= IDLE;
                    end else begin
                      state_q <= ENTRY;
                    end
                  end else begin
                    state_q <= state_q;
                  end
                end
`endif
                default: begin
                  // Remaining codes are accepted and ignored.
                  state_q <= state_q;
                end
              endcase
            end
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          // Unreachable encoding: recover to an empty, ready entry.
          state_q    <= IDLE;
          value_q    <= '0;
          count_q    <= 4'd0;
          overflow_q <= 1'b0;
          valid_q    <= 1'b0;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

  assign key_ready_o     = ready_q;
  assign value_o         = value_q;
  assign digit_count_o   = count_q;
  assign overflow_o      = overflow_q;
  assign operand_o       = operand_q;
  assign operand_valid_o = valid_q;

endmodule
